// File: rtl/rkv_responder.sv
// Register-file responder: request/grant handshake with a programmable grant latency.
// Optional address-stability violation checker enabled by RKV_RESP_VIOL_CHK_EN.
module rkv_responder #(
   parameter int unsigned WAIT_CYC = 2,
   parameter int unsigned DEPTH    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [7:0] addr,
   input  logic [7:0] data_i,
   output logic [7:0] data_o,
   output logic       data_oe,
   output logic       grt,
   output logic [7:0] viol_cnt
);

   typedef enum logic [1:0] {IDLE, WAIT, GRANT, DONE} state_t;

   localparam logic [3:0] LAST = 4'(WAIT_CYC - 1);

   state_t     state, state_nxt;
   logic [7:0] addr_l, addr_l_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [7:0] mem [DEPTH];
   logic [7:0] rd_nxt;
   logic       oe_nxt;
`ifdef RKV_RESP_VIOL_CHK_EN
   logic       viol_inc;
`endif

   always_comb begin
      state_nxt  = state;
      addr_l_nxt = addr_l;
      cnt_nxt    = cnt;
`ifdef RKV_RESP_VIOL_CHK_EN
      viol_inc   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (req) begin
               addr_l_nxt = addr;
               cnt_nxt    = '0;
               state_nxt  = (WAIT_CYC == 0) ? GRANT : WAIT;
            end
         end
         WAIT: begin
            if (!req) begin
               state_nxt = IDLE;
            end
`ifdef RKV_RESP_VIOL_CHK_EN
            else if (addr != addr_l) begin
               state_nxt = IDLE;
               viol_inc  = 1'b1;
            end
`endif
            else if (cnt == LAST) begin
               state_nxt = GRANT;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         GRANT: state_nxt = DONE;
         DONE: begin
            if (!req) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered yet valid in GRANT
      oe_nxt = (state_nxt == GRANT) && !addr_l_nxt[7];
      rd_nxt = '0;
      if (oe_nxt) rd_nxt = (addr_l_nxt[6:4] == 3'b000) ? mem[addr_l_nxt[3:0]] : 8'hEE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         addr_l  <= '0;
         cnt     <= '0;
         grt     <= 1'b0;
         data_oe <= 1'b0;
         data_o  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state   <= state_nxt;
         addr_l  <= addr_l_nxt;
         cnt     <= cnt_nxt;
         grt     <= (state_nxt == GRANT);
         data_oe <= oe_nxt;
         data_o  <= rd_nxt;
         if (state == GRANT && addr_l[7] && addr_l[6:4] == 3'b000)
            mem[addr_l[3:0]] <= data_i;
      end
   end

`ifdef RKV_RESP_VIOL_CHK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         viol_cnt <= '0;
      else if (viol_inc && viol_cnt != 8'hFF)
         viol_cnt <= viol_cnt + 8'd1;
   end
`else
   assign viol_cnt = '0;
`endif

endmodule

// File: doc/rkv_responder.md
RKV_RESPONDER -- requirements
Module: rkv_responder

Interface
REQ-001 Parameter WAIT_CYC, default 2, meaning grant latency in clk cycles after request acceptance; legal range 0..15.
REQ-002 Parameter DEPTH, default 16, meaning number of 8-bit register-file entries; fixed at 16 in this release.
REQ-003 clk  input  1  rising-edge clock; the block has only this one clock.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req  input  1  request from the initiator; level, held until grant.
REQ-006 addr  input  8  addr[7]=1 write, 0 read; addr[3:0] entry index; addr[6:4] must be 0.
REQ-007 data_i  input  8  write data from the initiator.
REQ-008 data_o  output  8  read data, valid only while data_oe=1.
REQ-009 data_oe  output  1  read-data drive enable for the bidirectional data bus.
REQ-010 grt  output  1  grant, a one-cycle pulse per accepted transaction.
REQ-011 viol_cnt  output  8  saturating protocol-violation count (see Configuration).

Function
REQ-012 The FSM SHALL have states IDLE, WAIT, GRANT and DONE, with all outputs registered.
REQ-013 IDLE with req=1 at edge E0 SHALL latch addr, clear the wait counter, and enter WAIT; if WAIT_CYC=0 it SHALL enter GRANT directly.
REQ-014 WAIT SHALL increment the counter each cycle and enter GRANT on the edge where the counter equals WAIT_CYC-1, so that grt rises at edge E0+WAIT_CYC.
REQ-015 WAIT with req sampled 0 SHALL return to IDLE with no grant, no write and no read drive.
REQ-016 GRANT SHALL last exactly one cycle with grt=1, then enter DONE unconditionally.
REQ-017 Write in range: at the edge leaving GRANT, the block SHALL store data_i into entry addr_latched[3:0].
REQ-018 Read in range: during the GRANT cycle, data_o SHALL equal entry addr_latched[3:0] and data_oe SHALL be 1.
REQ-019 Out of range (addr_latched[6:4]!=0): grt SHALL still pulse; a write SHALL be discarded; a read SHALL return 8'hEE.
REQ-020 Outside GRANT, data_oe SHALL be 0 and data_o SHALL be 8'h00.
REQ-021 DONE SHALL remain until req is sampled 0, then enter IDLE; one idle cycle is therefore mandatory between transactions.
REQ-022 A req held high through DONE SHALL NOT start a second transaction.

Reset
REQ-023 Asserting rst SHALL immediately force the FSM to IDLE and set grt=0, data_oe=0, data_o=0, viol_cnt=0, counter=0, and all register-file entries to 8'h00.
REQ-024 Reset asserted mid-transaction SHALL abort it with no write, including when asserted during GRANT.
REQ-025 Deassertion SHALL take effect at the first clk edge with rst=0, and the first acceptance SHALL be possible at that edge.

Configuration
REQ-026 Macro RKV_RESP_VIOL_CHK_EN defined: in WAIT, an addr that differs from addr_latched SHALL abort to IDLE with no grant, and viol_cnt SHALL increment, saturating at 8'hFF.
REQ-027 RKV_RESP_VIOL_CHK_EN undefined: addr SHALL be ignored after acceptance, and viol_cnt SHALL be tied to 8'h00.

Verification
REQ-028 Reset, then write with WAIT_CYC=2: req=1, addr=8'h83, data_i=8'h5A at E0 -> grt=1 only in cycle after E2; entry 3 = 8'h5A.
REQ-029 Read-back: req=1, addr=8'h03 -> grt pulse with data_o=8'h5A and data_oe=1 in the same cycle; data_oe=0 in every other cycle.
REQ-030 Abort: req=1, addr=8'h81, req dropped after 1 cycle -> no grt; entry 1 stays 8'h00; FSM back in IDLE.
REQ-031 Out of range: read addr=8'h15 -> grt pulse with data_o=8'hEE; write addr=8'h95, data_i=8'h77 -> no entry changes.
REQ-032 Req held high 5 cycles after grant -> exactly one grt; req low for 1 cycle, then high -> second grt at E0+WAIT_CYC.
REQ-033 With RKV_RESP_VIOL_CHK_EN: addr changes 8'h02 -> 8'h04 during WAIT -> no grt and viol_cnt=1; 300 violations -> viol_cnt=8'hFF; rst pulse mid-WAIT -> viol_cnt=0 and no grt.
